glove_tracker: RTL
==================

Name: glove_tracker

Overview:
- Consumes the camera-side pixel stream after colour classification. Per frame, accumulates the area and coordinate sums of glove-coloured pixels.
- At frame end, runs a sequential divider to produce the glove centroid, a presence flag and a debounced open/closed state.
- Supplies the glove x/y and closed inputs that the game logic consumes; one instance per glove.

Parameters:
- MIN_AREA, 64: minimum matched-pixel count for the glove to be reported present.
- CLOSED_AREA, 1500: a present glove with area below this is a raw "closed" sample.
- DEBOUNCE, 3: consecutive agreeing present frames required to change glove_closed (1..15).

Ports:
- vclock  input  1  pixel clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low; 0 initializes the block.
- hcount  input  11  column of the current camera pixel (0..1023).
- vcount  input  10  row of the current camera pixel (0..767).
- pixel_valid  input  1  1 = hcount/vcount/match describe an active pixel this cycle.
- match  input  1  1 = current pixel classified as glove colour.
- frame_end  input  1  single-cycle pulse after the last pixel of a frame.
- glove_x  output  11  centroid column.
- glove_y  output  10  centroid row.
- glove_area  output  20  matched-pixel count of the last completed frame.
- glove_present  output  1  last completed frame had area >= MIN_AREA.
- glove_closed  output  1  debounced closed state.
- update  output  1  one-cycle pulse when outputs change for a new frame.
- busy  output  1  divider running.
- overrun  output  1  one-cycle pulse when a frame was discarded.

Behaviour:
- Reset (reset=0): all outputs 0; accumulators 0; debounce counter 0; FSM to ACCUM.
- Accumulators: cnt 20 b, sum_x 31 b, sum_y 30 b. Each cycle with pixel_valid & match: cnt+=1, sum_x+=hcount, sum_y+=vcount. This runs in every FSM state.
- The pixel on the frame_end cycle belongs to the ending frame.
- FSM states: ACCUM, DIV, DONE.
- ACCUM, frame_end=1:
  - Snapshot cnt/sum_x/sum_y (including that cycle's pixel) into divider registers.
  - Clear the accumulators on the same edge.
  - glove_area <= snapshot cnt.
  - If snapshot cnt < MIN_AREA: glove_present <= 0; glove_x/y hold; go to DONE.
  - Otherwise go to DIV.
- DIV:
  - Two restoring dividers share one bit counter and produce floor(sum_x/cnt) and floor(sum_y/cnt).
  - One quotient bit per cycle, 31 cycles.
  - busy=1 throughout.
  - Then go to DONE.
- DONE (one cycle):
  - Load quotients: glove_x = q_x[10:0], glove_y = q_y[9:0]. These cannot overflow because a mean is bounded by the max coordinate.
  - glove_present <= 1; update debounce; pulse update; go to ACCUM.
- Small-area frames also pass through DONE and pulse update, with x/y held.
- Latency:
  - update is high exactly 33 cycles after the frame_end edge for present frames.
  - update is high exactly 1 cycle after the frame_end edge for absent frames.
- frame_end while in DIV or DONE:
  - Accumulators are cleared, discarding the frame in progress.
  - overrun pulses next cycle.
  - The current division completes unaffected.
- Debounce (evaluated in DONE):
  - raw = present & (area < CLOSED_AREA).
  - If raw == glove_closed: counter <= 0.
  - Else counter += 1; when counter reaches DEBOUNCE, toggle glove_closed and set counter <= 0.
  - Absent frame: glove_closed holds; counter <= 0.
- Asynchronous reset mid-DIV aborts immediately. No update is issued for the interrupted frame.

Test Plan:
- Square frame: match 8x8 square, hcount 100..107, vcount 200..207, then frame_end.
  - update exactly 33 cycles later.
  - glove_x=103, glove_y=203, glove_area=64, glove_present=1, glove_closed=0.
- Below threshold: after the previous frame, a frame with 63 matched pixels at hcount 500.
  - update 1 cycle after frame_end.
  - glove_present=0, glove_area=63, glove_x=103 and glove_y=203 held.
- Debounce: DEBOUNCE=3, 10x10 square (area 100) for three frames.
  - glove_closed stays 0 after updates 1 and 2, rises at update 3.
  - Then a 40x40 square (area 1600) for two frames, one absent frame, three more 40x40 frames.
  - glove_closed falls only at the third of the final three updates.
- Overrun: assert frame_end 10 cycles after a previous frame_end (busy=1).
  - overrun pulses once; the first frame's update still appears at +33.
  - Pixels matched before the second frame_end are not counted in the next frame's area.
- Reset mid-DIV: drive reset=0 at cycle 15 of DIV.
  - All outputs 0 immediately.
  - No update after reset=1 until a new frame_end.
- Extreme corners: single-frame match of pixels (1023,767) x64 and (0,0) x64.
  - glove_area=128, glove_x=511, glove_y=383; no wrap in sums.

Source files
------------

// File: rtl/glove_tracker.sv
// Per-frame glove tracker: accumulates matched-pixel area and coordinate sums,
// then divides at frame end to report centroid, presence and debounced closed state.
module glove_tracker #(
  parameter int MIN_AREA    = 64,
  parameter int CLOSED_AREA = 1500,
  parameter int DEBOUNCE    = 3
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        pixel_valid,
  input  logic        match,
  input  logic        frame_end,
  output logic [10:0] glove_x,
  output logic [9:0]  glove_y,
  output logic [19:0] glove_area,
  output logic        glove_present,
  output logic        glove_closed,
  output logic        update,
  output logic        busy,
  output logic        overrun
);

  localparam logic [19:0] MIN_AREA_W    = 20'(MIN_AREA);
  localparam logic [19:0] CLOSED_AREA_W = 20'(CLOSED_AREA);
  localparam logic [3:0]  DEBOUNCE_W    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ACCUM, DIV, DONE} state_t;

  state_t      state_reg;
  logic [19:0] cnt_reg;
  logic [30:0] sum_x_reg;
  logic [29:0] sum_y_reg;
  logic [19:0] divisor_reg;
  logic [1:0][30:0] dvd_reg;
  logic [1:0][19:0] rem_reg;
  logic [4:0]  bit_cnt_reg;
  logic        frame_present_reg;
  logic [3:0]  deb_cnt_reg;

  logic        hit;
  logic [19:0] cnt_next;
  logic [30:0] sum_x_next;
  logic [29:0] sum_y_next;
  logic [1:0][30:0] dvd_step;
  logic [1:0][19:0] rem_step;
  logic        raw_closed;

  assign hit        = pixel_valid & match;
  assign cnt_next   = cnt_reg + 20'(hit);
  assign sum_x_next = sum_x_reg + (hit ? {20'd0, hcount} : 31'd0);
  assign sum_y_next = sum_y_reg + (hit ? {20'd0, vcount} : 30'd0);
  assign raw_closed = glove_area < CLOSED_AREA_W;

  // Restoring division: the dividend register shifts left and collects
  // quotient bits in its LSB, so after 31 steps it holds the quotient.
  for (genvar gi = 0; gi < 2; gi++) begin : g_div
    logic [20:0] trial;
    logic        take;
    assign trial        = {rem_reg[gi], dvd_reg[gi][30]};
    assign take         = trial >= {1'b0, divisor_reg};
    assign rem_step[gi] = take ? 20'(trial - {1'b0, divisor_reg}) : trial[19:0];
    assign dvd_step[gi] = {dvd_reg[gi][29:0], take};
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      state_reg         <= ACCUM;
      cnt_reg           <= '0;
      sum_x_reg         <= '0;
      sum_y_reg         <= '0;
      divisor_reg       <= '0;
      dvd_reg           <= '0;
      rem_reg           <= '0;
      bit_cnt_reg       <= '0;
      frame_present_reg <= 1'b0;
      deb_cnt_reg       <= '0;
      glove_x           <= '0;
      glove_y           <= '0;
      glove_area        <= '0;
      glove_present     <= 1'b0;
      glove_closed      <= 1'b0;
      update            <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      update  <= 1'b0;
      overrun <= 1'b0;

      // A frame_end always closes the frame in progress, kept or not.
      if (frame_end) begin
        cnt_reg   <= '0;
        sum_x_reg <= '0;
        sum_y_reg <= '0;
      end else begin
        cnt_reg   <= cnt_next;
        sum_x_reg <= sum_x_next;
        sum_y_reg <= sum_y_next;
      end

      case (state_reg)
        ACCUM: begin
          if (frame_end) begin
            divisor_reg <= cnt_next;
            dvd_reg[0]  <= sum_x_next;
            dvd_reg[1]  <= {1'b0, sum_y_next};
            rem_reg     <= '0;
            bit_cnt_reg <= 5'd31;
            glove_area  <= cnt_next;
            if (cnt_next < MIN_AREA_W) begin
              glove_present     <= 1'b0;
              frame_present_reg <= 1'b0;
              state_reg         <= DONE;
            end else begin
              frame_present_reg <= 1'b1;
              busy              <= 1'b1;
              state_reg         <= DIV;
            end
          end
        end

        DIV: begin
          overrun <= frame_end;
          if (bit_cnt_reg == 5'd0) begin
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
            dvd_reg     <= dvd_step;
            rem_reg     <= rem_step;
            bit_cnt_reg <= bit_cnt_reg - 5'd1;
          end
        end

        DONE: begin
          overrun   <= frame_end;
          update    <= 1'b1;
          state_reg <= ACCUM;
          if (frame_present_reg) begin
            glove_x       <= dvd_reg[0][10:0];
            glove_y       <= dvd_reg[1][9:0];
            glove_present <= 1'b1;
            if (raw_closed == glove_closed) begin
              deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEBOUNCE_W - 4'd1) begin
              glove_closed <= ~glove_closed;
              deb_cnt_reg  <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 4'd1;
            end
          end else begin
            deb_cnt_reg <= '0;
          end
        end

        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule
